// File: rtl/interleave_example_control_s_axi.sv
// ---------------------------------------------------------------------------
// interleave_example_control_s_axi
//
// AXI4-Lite slave register file and run-control sequencer for
// interleave_example_vadd. Host software programs the kernel arguments and
// sets CTRL.start. The block then issues a one-cycle ap_start pulse and
// tracks busy/done from the kernel's ap_done pulse.
//
// Register map (word addresses, the low two address bits are ignored):
//   0x00 CTRL   bit0 start/busy (RW1S), bit1 done (RO, clear-on-read),
//               bit2 idle (RO)
//   0x04 GIE    bit0 global interrupt enable      (IRQ build only)
//   0x08 IER    bit0 done interrupt enable        (IRQ build only)
//   0x0C ISR    bit0 done status, toggle-on-write-1 (IRQ build only)
//   0x10 offset[31:0]   0x14 offset[63:32]
//   0x18 xfer_size      0x1C constant
//
// Ports:
//   aclk, aresetn             clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*           AXI4-Lite write address/data/response
//   s_axi_ar*/r*              AXI4-Lite read address/data
//   ap_start (out)            one-cycle start pulse to the kernel
//   ap_done  (in)             one-cycle completion pulse from the kernel
//   ctrl_addr_offset (out)    buffer offset argument
//   ctrl_xfer_size_in_bytes   transfer size argument
//   ctrl_constant (out)       adder constant argument
//   interrupt (out)           level interrupt, only with the macro below
//
// Configuration macro: INTERLEAVE_CTRL_IRQ_EN
//   defined   -> GIE/IER/ISR implemented, interrupt port present
//   undefined -> no interrupt port, 0x04..0x0C read 0 and ignore writes
// ---------------------------------------------------------------------------
module interleave_example_control_s_axi #(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_ADDER_BIT_WIDTH  = 32
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    output logic [1:0]                      s_axi_bresp,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            ap_start,
    input  logic                            ap_done,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_size_in_bytes,
`ifdef INTERLEAVE_CTRL_IRQ_EN
    output logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_constant,
    output logic                            interrupt
`else
    output logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_constant
`endif
);

    localparam logic [1:0] W_ADDR = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_ADDR = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Register word indices (byte address >> 2).
    localparam int                AW     = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [AW-1:0]     A_CTRL  = AW'(0);
`ifdef INTERLEAVE_CTRL_IRQ_EN
    localparam logic [AW-1:0]     A_GIE   = AW'(1);
    localparam logic [AW-1:0]     A_IER   = AW'(2);
    localparam logic [AW-1:0]     A_ISR   = AW'(3);
`endif
    localparam logic [AW-1:0]     A_OFFLO = AW'(4);
    localparam logic [AW-1:0]     A_OFFHI = AW'(5);
    localparam logic [AW-1:0]     A_XFER  = AW'(6);
    localparam logic [AW-1:0]     A_CONST = AW'(7);

    function automatic logic [31:0] width_mask(input int bits);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (int'(i) < bits) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Bits above each argument's port width are never stored, so they read 0.
    localparam logic [31:0] OFFLO_MASK = width_mask(C_M_AXI_ADDR_WIDTH);
    localparam logic [31:0] OFFHI_MASK = width_mask(C_M_AXI_ADDR_WIDTH - 32);
    localparam logic [31:0] XFER_MASK  = width_mask(C_XFER_SIZE_WIDTH);
    localparam logic [31:0] CONST_MASK = width_mask(C_ADDER_BIT_WIDTH);

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] data,
                                          input logic [3:0]  strb,
                                          input logic [31:0] mask);
        logic [31:0] r;
        r = old_v;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
        end
        return r & mask;
    endfunction

    logic          init_q;
    logic [1:0]    wstate_q, wstate_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [0:0]    rstate_q, rstate_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ap_start_q, ap_start_d;
    logic [31:0]   offlo_q, offlo_d;
    logic [31:0]   offhi_q, offhi_d;
    logic [31:0]   xfer_q, xfer_d;
    logic [31:0]   const_q, const_d;
`ifdef INTERLEAVE_CTRL_IRQ_EN
    logic          gie_q, gie_d;
    logic          ier_q, ier_d;
    logic          isr_q, isr_d;
    logic          irq_q;
`endif

    logic          aw_hs, w_hs, ar_hs;
    logic [AW-1:0] ar_word;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Ready outputs stay low until the first edge after reset release.
    assign s_axi_awready = init_q && (wstate_q == W_ADDR);
    assign s_axi_wready  = (wstate_q == W_DATA);
    assign s_axi_bvalid  = (wstate_q == W_RESP);
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = init_q && (rstate_q == R_ADDR);
    assign s_axi_rvalid  = (rstate_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;

    assign aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_hs    = s_axi_wvalid && s_axi_wready;
    assign ar_hs   = s_axi_arvalid && s_axi_arready;
    assign ar_word = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

    assign ap_start                = ap_start_q;
    assign ctrl_addr_offset        = C_M_AXI_ADDR_WIDTH'({offhi_q, offlo_q});
    assign ctrl_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(xfer_q);
    assign ctrl_constant           = C_ADDER_BIT_WIDTH'(const_q);
`ifdef INTERLEAVE_CTRL_IRQ_EN
    assign interrupt = irq_q;
`endif

    // Write channel FSM.
    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        case (wstate_q)
            W_ADDR: if (aw_hs) begin
                waddr_d  = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                wstate_d = W_DATA;
            end
            W_DATA: if (w_hs) wstate_d = W_RESP;
            W_RESP: if (s_axi_bready) wstate_d = W_ADDR;
            default: wstate_d = W_ADDR;
        endcase
    end

    // Read channel FSM; read data is captured at the AR handshake.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        case (rstate_q)
            R_ADDR: if (ar_hs) begin
                rstate_d = R_DATA;
                rdata_d  = '0;
                case (ar_word)
                    A_CTRL: begin
                        rdata_d[0] = busy_q;
                        rdata_d[1] = done_q;
                        rdata_d[2] = ~busy_q;
                    end
`ifdef INTERLEAVE_CTRL_IRQ_EN
                    A_GIE:   rdata_d[0] = gie_q;
                    A_IER:   rdata_d[0] = ier_q;
                    A_ISR:   rdata_d[0] = isr_q;
`endif
                    A_OFFLO: rdata_d = offlo_q;
                    A_OFFHI: rdata_d = offhi_q;
                    A_XFER:  rdata_d = xfer_q;
                    A_CONST: rdata_d = const_q;
                    default: rdata_d = '0;
                endcase
            end
            R_DATA: if (s_axi_rready) rstate_d = R_ADDR;
            default: rstate_d = R_ADDR;
        endcase
    end

    // Register file and run control. Event order below matters: the
    // done/ISR set from ap_done is applied last so it wins over a same-cycle
    // clear-on-read or ISR toggle.
    always_comb begin
        busy_d     = busy_q;
        done_d     = done_q;
        ap_start_d = 1'b0;
        offlo_d    = offlo_q;
        offhi_d    = offhi_q;
        xfer_d     = xfer_q;
        const_d    = const_q;
`ifdef INTERLEAVE_CTRL_IRQ_EN
        gie_d      = gie_q;
        ier_d      = ier_q;
        isr_d      = isr_q;
`endif
        if (w_hs) begin
            case (waddr_q)
                A_CTRL: if (s_axi_wdata[0] && s_axi_wstrb[0] && !busy_q) begin
                    ap_start_d = 1'b1;
                    busy_d     = 1'b1;
                end
`ifdef INTERLEAVE_CTRL_IRQ_EN
                A_GIE: if (s_axi_wstrb[0]) gie_d = s_axi_wdata[0];
                A_IER: if (s_axi_wstrb[0]) ier_d = s_axi_wdata[0];
                A_ISR: if (s_axi_wstrb[0] && s_axi_wdata[0]) isr_d = ~isr_q;
`endif
                A_OFFLO: if (!busy_q) offlo_d = merge(offlo_q, s_axi_wdata, s_axi_wstrb, OFFLO_MASK);
                A_OFFHI: if (!busy_q) offhi_d = merge(offhi_q, s_axi_wdata, s_axi_wstrb, OFFHI_MASK);
                A_XFER:  if (!busy_q) xfer_d  = merge(xfer_q,  s_axi_wdata, s_axi_wstrb, XFER_MASK);
                A_CONST: if (!busy_q) const_d = merge(const_q, s_axi_wdata, s_axi_wstrb, CONST_MASK);
                default: ;
            endcase
        end
        if (ar_hs && (ar_word == A_CTRL)) done_d = 1'b0;
        if (ap_done && busy_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
`ifdef INTERLEAVE_CTRL_IRQ_EN
            if (ier_q) isr_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            init_q     <= 1'b0;
            wstate_q   <= W_ADDR;
            waddr_q    <= '0;
            rstate_q   <= R_ADDR;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ap_start_q <= 1'b0;
            offlo_q    <= '0;
            offhi_q    <= '0;
            xfer_q     <= '0;
            const_q    <= '0;
`ifdef INTERLEAVE_CTRL_IRQ_EN
            gie_q      <= 1'b0;
            ier_q      <= 1'b0;
            isr_q      <= 1'b0;
            irq_q      <= 1'b0;
`endif
        end else begin
            init_q     <= 1'b1;
            wstate_q   <= wstate_d;
            waddr_q    <= waddr_d;
            rstate_q   <= rstate_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ap_start_q <= ap_start_d;
            offlo_q    <= offlo_d;
            offhi_q    <= offhi_d;
            xfer_q     <= xfer_d;
            const_q    <= const_d;
`ifdef INTERLEAVE_CTRL_IRQ_EN
            gie_q      <= gie_d;
            ier_q      <= ier_d;
            isr_q      <= isr_d;
            irq_q      <= gie_q & ier_q & isr_q;
`endif
        end
    end

endmodule

// File: doc/interleave_example_control_s_axi.md
# interleave_example_control_s_axi

AXI4-Lite slave register file and run-control sequencer feeding `interleave_example_vadd`. Host software writes the kernel arguments (buffer offset, transfer size, adder constant) and a start bit. The block issues a single-cycle `ap_start` pulse and tracks busy/done from the returned `ap_done` pulse. An optional completion interrupt is provided.

## Interface
- `C_S_AXI_ADDR_WIDTH`, 6: AXI4-Lite address width; register map occupies 0x00–0x1F.
- `C_S_AXI_DATA_WIDTH`, 32: AXI4-Lite data width; only 32 is supported.
- `C_M_AXI_ADDR_WIDTH`, 64: width of `ctrl_addr_offset`.
- `C_XFER_SIZE_WIDTH`, 32: width of `ctrl_xfer_size_in_bytes`; must be ≤32.
- `C_ADDER_BIT_WIDTH`, 32: width of `ctrl_constant`; must be ≤32.

Ports:
- `aclk` in 1: the single clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `s_axi_awvalid`/`s_axi_awready` in/out 1, `s_axi_awaddr` in C_S_AXI_ADDR_WIDTH: write address channel.
- `s_axi_wvalid`/`s_axi_wready` in/out 1, `s_axi_wdata` in 32, `s_axi_wstrb` in 4: write data channel.
- `s_axi_bvalid` out 1, `s_axi_bready` in 1, `s_axi_bresp` out 2: write response, always 2'b00.
- `s_axi_arvalid`/`s_axi_arready` in/out 1, `s_axi_araddr` in C_S_AXI_ADDR_WIDTH: read address channel.
- `s_axi_rvalid` out 1, `s_axi_rready` in 1, `s_axi_rdata` out 32, `s_axi_rresp` out 2: read data channel; `s_axi_rresp` is always 2'b00.
- `ap_start` out 1: one-cycle start pulse to the kernel.
- `ap_done` in 1: one-cycle completion pulse from the kernel.
- `ctrl_addr_offset` out C_M_AXI_ADDR_WIDTH: buffer offset argument.
- `ctrl_xfer_size_in_bytes` out C_XFER_SIZE_WIDTH: transfer size argument.
- `ctrl_constant` out C_ADDER_BIT_WIDTH: adder constant argument.
- `interrupt` out 1: level interrupt; exists only with the configuration macro.

## Operation
- Register map (word addresses; the low 2 address bits are ignored):
  - 0x00 CTRL: bit0 start/busy (RW1S), bit1 done (RO, clear-on-read), bit2 idle (RO). The remaining bits read 0.
  - 0x04 GIE, bit0; 0x08 IER, bit0 done-enable; 0x0C ISR, bit0, toggle-on-write-1.
  - 0x10 offset[31:0]; 0x14 offset[63:32]; 0x18 xfer_size; 0x1C constant.
- Argument registers honour `s_axi_wstrb` per byte. Bits above the port width are dropped on write and read as 0. Argument registers drive the output ports directly.
- Writes to the argument registers while busy are ignored, but still get an OKAY response.
- Unmapped addresses read 0; writes to them are ignored.
- Start: a write to CTRL with wdata[0]=1 and wstrb[0]=1 while idle causes the following:
  - next cycle `ap_start`=1 for exactly one cycle;
  - busy=1, idle=0.
  - A start write while busy is ignored.
- Completion: `ap_done`=1 while busy clears busy, sets idle=1 and done=1, and sets ISR[0] if IER[0]=1. `ap_done` while idle is ignored.
- Write FSM: W_ADDR (awready=1) → W_DATA (wready=1) → W_RESP (bvalid=1, held until bready) → W_ADDR.
- Read FSM: R_ADDR (arready=1) → R_DATA (rvalid=1, rdata registered at the AR handshake, held stable until rready) → R_ADDR.
- The read and write FSMs run independently.

## Timing
- Reset values:
  - all VALID/READY outputs 0, except `s_axi_awready`=1 and `s_axi_arready`=1 after the first edge following deassertion;
  - `ap_start`=0, busy=0, done=0, idle=1;
  - all argument, GIE, IER and ISR registers 0; `interrupt`=0.
- Read latency: rvalid is asserted the cycle after the AR handshake. Write response: bvalid is asserted the cycle after the W handshake.
- Done clear-on-read happens at the AR handshake of address 0x00. If `ap_done` arrives in the same cycle:
  - set has priority, so done stays 1;
  - that read returns done=0.
- ISR toggle write in the same cycle as a done-set: the set wins.
- `interrupt` = registered (GIE & IER[0] & ISR[0]), so it asserts one cycle after ISR sets.
- `aresetn` asserted mid-transaction: all FSMs return to their address state and any pending `ap_start` is dropped.

## Configuration
- `INTERLEAVE_CTRL_IRQ_EN` defined: GIE/IER/ISR are implemented and the `interrupt` port exists.
- `INTERLEAVE_CTRL_IRQ_EN` undefined: no `interrupt` port; 0x04–0x0C read 0 and ignore writes.

## Test plan
- Write 0x10=0x1000, 0x14=0x1, 0x18=0x4000, 0x1C=0x5 → `ctrl_addr_offset`=0x1_0000_1000, `ctrl_xfer_size_in_bytes`=0x4000, `ctrl_constant`=5; each bvalid asserts one cycle after its W handshake.
- Write CTRL=0x1 → `ap_start` high exactly one cycle; CTRL reads 0x1. A second start write while busy → no pulse.
- Pulse `ap_done` → CTRL reads 0x6, then the next CTRL read returns 0x4.
- IRQ build:
  - GIE=1, IER=1, start, then `ap_done` → `interrupt` rises one cycle after ISR sets.
  - Write ISR=1 → `interrupt` drops the next cycle.
- Same-cycle CTRL read AR handshake and `ap_done` → rdata done bit=0; the following read returns done=1.
- Write 0x18 with wstrb=4'b0010 and wdata=0xAABBCCDD while busy → register unchanged. The same write while idle → byte1 = 0xCC only.
